fetch_decode_reg: RTL and testbench

IF/ID pipeline boundary between `fetch_cycle` and the decode stage. It pairs the synchronous instruction-ROM word with the PC that addressed it, because the word arrives one cycle after the PC. It presents an aligned {instr, pc, pcPlus4, valid} bundle to decode and applies the hazard unit's stall and the branch unit's flush. A one-entry skid register keeps the held instruction correct while the ROM keeps reading during a stall.

---
 rtl/fetch_decode_reg_pkg.sv | 24 ++
 rtl/fetch_decode_reg_instr_skid.sv | 44 ++++
 rtl/fetch_decode_reg.sv | 114 +++++++++++
 tb/tb_fetch_decode_reg.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_reg_pkg.sv
// Shared definitions for the IF/ID boundary: datapath width, bubble encoding
// and the per-edge action decode (flush > stall > run).
package fetch_decode_reg_pkg;

   localparam int unsigned DEF_WIDTH     = 32;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ACT_RUN,
      ACT_STALL,
      ACT_FLUSH
   } edge_act_e;

   // Flush squashes the wrong path even while the hazard unit is holding.
   function automatic edge_act_e decode_act(input logic flush, input logic stall);
      if (flush)
         return ACT_FLUSH;
      else if (stall)
         return ACT_STALL;
      else
         return ACT_RUN;
   endfunction

endpackage

// File: rtl/fetch_decode_reg_instr_skid.sv
// One-entry skid for the instruction word: keeps the first ROM word seen during
// a stall, since the ROM keeps reading the held PC afterwards.
module instr_skid
   import fetch_decode_reg_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             capture_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] instr_i,
   output logic [WIDTH-1:0] instr_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] instr_q, instr_d;
   logic             valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      valid_d = valid_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (capture_i && !valid_q) begin
         instr_d = instr_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_decode_reg.sv
// IF/ID register: aligns the synchronous ROM word with the PC that addressed it
// and applies stall/flush, presenting a registered bundle to decode.
module fetch_decode_reg
   import fetch_decode_reg_pkg::*;
#(
   parameter int unsigned      WIDTH     = DEF_WIDTH,
   parameter logic [WIDTH-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] instr_in,
   input  logic [WIDTH-1:0] pc_in,
   input  logic [WIDTH-1:0] pcPlus4_in,
   input  logic             stall,
   input  logic             flush,
   output logic [WIDTH-1:0] instr_d,
   output logic [WIDTH-1:0] pc_d,
   output logic [WIDTH-1:0] pcPlus4_d,
   output logic             valid_d
);

   edge_act_e        act;
   logic [WIDTH-1:0] a_pc_q, a_pc_d;
   logic [WIDTH-1:0] a_pcp4_q, a_pcp4_d;
   logic             a_valid_q, a_valid_d;
   logic [WIDTH-1:0] o_instr_q, o_instr_d;
   logic [WIDTH-1:0] o_pc_q, o_pc_d;
   logic [WIDTH-1:0] o_pcp4_q, o_pcp4_d;
   logic             o_valid_q, o_valid_d;
   logic [WIDTH-1:0] s_instr;
   logic             s_valid;
   logic [WIDTH-1:0] instr_src;

   assign act = decode_act(flush, stall);

   instr_skid #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .capture_i (act == ACT_STALL),
      .clear_i   (act != ACT_STALL),
      .instr_i   (instr_in),
      .instr_o   (s_instr),
      .valid_o   (s_valid)
   );

   assign instr_src = s_valid ? s_instr : instr_in;

   always_comb begin
      a_pc_d    = a_pc_q;
      a_pcp4_d  = a_pcp4_q;
      a_valid_d = a_valid_q;
      o_instr_d = o_instr_q;
      o_pc_d    = o_pc_q;
      o_pcp4_d  = o_pcp4_q;
      o_valid_d = o_valid_q;
      unique case (act)
         ACT_FLUSH: begin
            o_instr_d = NOP_INSTR;
            o_pc_d    = '0;
            o_pcp4_d  = '0;
            o_valid_d = 1'b0;
            a_pc_d    = pc_in;
            a_pcp4_d  = pcPlus4_in;
            a_valid_d = 1'b0;
         end
         ACT_STALL: begin
         end
         default: begin
            if (a_valid_q) begin
               o_instr_d = instr_src;
               o_pc_d    = a_pc_q;
               o_pcp4_d  = a_pcp4_q;
               o_valid_d = 1'b1;
            end else begin
               o_instr_d = NOP_INSTR;
               o_pc_d    = '0;
               o_pcp4_d  = '0;
               o_valid_d = 1'b0;
            end
            a_pc_d    = pc_in;
            a_pcp4_d  = pcPlus4_in;
            a_valid_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_pc_q    <= '0;
         a_pcp4_q  <= '0;
         a_valid_q <= 1'b0;
         o_instr_q <= NOP_INSTR;
         o_pc_q    <= '0;
         o_pcp4_q  <= '0;
         o_valid_q <= 1'b0;
      end else begin
         a_pc_q    <= a_pc_d;
         a_pcp4_q  <= a_pcp4_d;
         a_valid_q <= a_valid_d;
         o_instr_q <= o_instr_d;
         o_pc_q    <= o_pc_d;
         o_pcp4_q  <= o_pcp4_d;
         o_valid_q <= o_valid_d;
      end
   end

   assign instr_d   = o_instr_q;
   assign pc_d      = o_pc_q;
   assign pcPlus4_d = o_pcp4_q;
   assign valid_d   = o_valid_q;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Bench for fetch_decode_reg: a fetch unit plus synchronous ROM drive the DUT,
// and decode-side outputs are checked against an edge-history reference model.
module tb_fetch_decode_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] target = '0;
   logic [31:0] pc_f;
   logic [31:0] rom_q;
   logic [31:0] instr_d, pc_d, pcPlus4_d;
   logic        valid_d;

   logic [31:0] rom [64];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_decode_reg #(
      .WIDTH     (32),
      .NOP_INSTR (NOP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .instr_in   (rom_q),
      .pc_in      (pc_f),
      .pcPlus4_in (pc_f + 32'd4),
      .stall      (stall),
      .flush      (flush),
      .instr_d    (instr_d),
      .pc_d       (pc_d),
      .pcPlus4_d  (pcPlus4_d),
      .valid_d    (valid_d)
   );

   // Fetch unit and synchronous ROM: ROM always reads the current PC.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_f  <= '0;
         rom_q <= '0;
      end else begin
         if (flush)
            pc_f <= target;
         else if (!stall)
            pc_f <= pc_f + 32'd4;
         rom_q <= rom[pc_f[7:2]];
      end
   end

   // Reference: after a stall edge nothing changes; after a flush edge a bubble;
   // after a run edge, the PC fetched at the previous non-stall edge, provided
   // that edge was itself a run edge.
   bit          have_ns;
   bit          ns_flush;
   logic [31:0] ns_pc;
   bit          exp_valid;
   logic [31:0] exp_pc;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         have_ns   = 1'b0;
         ns_flush  = 1'b0;
         ns_pc     = '0;
         exp_valid = 1'b0;
         exp_pc    = '0;
      end else if (flush) begin
         exp_valid = 1'b0;
         exp_pc    = '0;
         have_ns   = 1'b1;
         ns_flush  = 1'b1;
         ns_pc     = pc_f;
      end else if (!stall) begin
         exp_valid = have_ns && !ns_flush;
         exp_pc    = exp_valid ? ns_pc : 32'd0;
         have_ns   = 1'b1;
         ns_flush  = 1'b0;
         ns_pc     = pc_f;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      logic [31:0] e_instr;
      e_instr = exp_valid ? rom[exp_pc[7:2]] : NOP;
      chk({tag, ".instr"}, instr_d, e_instr);
      chk({tag, ".pc"}, pc_d, exp_pc);
      chk({tag, ".pcp4"}, pcPlus4_d, exp_valid ? exp_pc + 32'd4 : 32'd0);
      chk({tag, ".valid"}, {31'd0, valid_d}, {31'd0, exp_valid});
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, ".instr"}, instr_d, NOP);
      chk({tag, ".pc"}, pc_d, 32'd0);
      chk({tag, ".pcp4"}, pcPlus4_d, 32'd0);
      chk({tag, ".valid"}, {31'd0, valid_d}, 32'd0);
   endtask

   task automatic chk_valid_pc(input string tag, input logic [31:0] pc);
      chk({tag, ".pc"}, pc_d, pc);
      chk({tag, ".instr"}, instr_d, rom[pc[7:2]]);
      chk({tag, ".pcp4"}, pcPlus4_d, pc + 32'd4);
      chk({tag, ".valid"}, {31'd0, valid_d}, 32'd1);
   endtask

   // Drive one edge's controls from just after a falling edge, then check
   // the registered outputs at the next falling edge.
   task automatic cyc(input logic s, input logic f, input logic [31:0] tgt);
      stall  = s;
      flush  = f;
      target = tgt;
      @(posedge clk);
      @(negedge clk);
      chk_model("model");
   endtask

   initial begin
      rom[0] = 32'h0050_0093;
      for (int i = 1; i < 64; i++) rom[i] = $urandom;

      repeat (3) begin
         @(negedge clk);
         chk_bubble("reset");
      end
      rst = 1'b1;

      cyc(0, 0, 0);
      chk_bubble("fill_edge1");
      cyc(0, 0, 0);
      chk("fill_first_instr", instr_d, 32'h0050_0093);
      chk_valid_pc("fill_first", 32'd0);

      for (int i = 1; i < 8; i++) begin
         cyc(0, 0, 0);
         chk_valid_pc("stream", 32'(4 * i));
      end

      cyc(0, 1, 32'h0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk_valid_pc("restart0", 32'd0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk_valid_pc("restart8", 32'd8);

      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0);
         chk_valid_pc("stall_hold", 32'd8);
      end
      cyc(0, 0, 0);
      chk_valid_pc("stall_rel12", 32'd12);
      cyc(0, 0, 0);
      chk_valid_pc("stall_rel16", 32'd16);

      cyc(0, 1, 32'h40);
      chk_bubble("flush_b1");
      cyc(0, 0, 0);
      chk_bubble("flush_b2");
      cyc(0, 0, 0);
      chk_valid_pc("flush_tgt", 32'h40);

      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk_valid_pc("hold_pre", 32'h40);
      cyc(1, 1, 32'h80);
      chk_bubble("fs_b1");
      chk("fs_skid_clear", {31'd0, dut.s_valid}, 32'd0);
      cyc(0, 0, 0);
      chk_bubble("fs_b2");
      cyc(0, 0, 0);
      chk_valid_pc("fs_tgt", 32'h80);

      for (int i = 0; i < 400; i++)
         cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
             {24'd0, 6'($urandom_range(0, 63)), 2'b00});

      for (int i = 0; i < 6; i++) cyc(0, 0, 0);
      #2 rst = 1'b0;
      #1;
      chk_bubble("async_rst");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 40; i++)
         cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
             {24'd0, 6'($urandom_range(0, 63)), 2'b00});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
